// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: FSM state codes,
// Funct3 access-size codes, byte-enable patterns and small helpers.
package rv32i_lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_RSP  = 2'd2;
  localparam lsu_state_t ST_DONE = 2'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unknown Funct3 codes behave as a full word access.
  function automatic logic [2:0] norm_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: norm_size = f3;
      default:                        norm_size = F3_W;
    endcase
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (norm_size(f3))
      F3_H, F3_HU: is_misaligned = addr_lo[0];
      F3_W:        is_misaligned = (addr_lo != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
//
// Handshake: the master raises BusReq with BusWe/BusAddr/BusWData/BusBe and
// keeps all of them stable until the cycle BusGnt is high; that cycle is the
// transfer. A write completes with the grant (BusErr sampled with BusGnt). A
// read completes on the first cycle with BusRValid high at or after the grant
// (BusErr sampled with BusRValid). Responses outside a pending access are
// ignored by the master.
interface load_store_unit_if;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWData;
  logic [3:0]  BusBe;
  logic        BusGnt;
  logic        BusRValid;
  logic [31:0] BusRData;
  logic        BusErr;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData, BusBe,
    input  BusGnt, BusRValid, BusRData, BusErr
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData, BusBe,
    output BusGnt, BusRValid, BusRData, BusErr
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// plus load lane extraction with sign/zero extension.
module lsu_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data
);

  logic [2:0]  size;
  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Halfword lane uses addr[1] only, so an odd halfword address never
  // straddles lanes when alignment is not trapped.
  always_comb begin
    size      = norm_size(funct3);
    shifted   = bus_rdata >> {addr_lo, 3'b000};
    lane_b    = shifted[7:0];
    lane_h    = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    bus_be    = BE_WORD;
    bus_wdata = store_data;
    load_data = bus_rdata;
    case (size)
      F3_B: begin
        bus_be    = BE_BYTE << addr_lo;
        bus_wdata = {4{store_data[7:0]}};
        load_data = {{24{lane_b[7]}}, lane_b};
      end
      F3_BU: begin
        bus_be    = BE_BYTE << addr_lo;
        bus_wdata = {4{store_data[7:0]}};
        load_data = {24'd0, lane_b};
      end
      F3_H: begin
        bus_be    = BE_HALF << {addr_lo[1], 1'b0};
        bus_wdata = {2{store_data[15:0]}};
        load_data = {{16{lane_h[15]}}, lane_h};
      end
      F3_HU: begin
        bus_be    = BE_HALF << {addr_lo[1], 1'b0};
        bus_wdata = {2{store_data[15:0]}};
        load_data = {16'd0, lane_h};
      end
      default: begin
        bus_be    = BE_WORD;
        bus_wdata = store_data;
        load_data = bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: stalls the pipeline while a single bus
// access runs through IDLE -> REQ -> (RSP) -> DONE, with timeout abort.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword
// and word accesses without touching the bus.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          Funct3M,
  input  logic [31:0]         ALUResultM,
  input  logic [31:0]         WriteDataM,
  output logic                StallM,
  output logic [31:0]         ReadDataM,
  output logic                ErrM,
  load_store_unit_if.master   bus,
  output lsu_state_t          state_dbg
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_t  state, next_state;
  logic [CW-1:0] cnt;
  logic        req_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic        we_q, err_q;

  logic        start, illegal, misalign, timeout_hit;
  logic        fin, fin_err, fin_cap;
  logic [31:0] load_data;

  assign start       = (state == ST_IDLE) && (MemReadM || MemWriteM);
  assign illegal     = MemReadM && MemWriteM;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(Funct3M, ALUResultM[1:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (f3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (wdata_q),
    .bus_rdata  (bus.BusRData),
    .bus_be     (bus.BusBe),
    .bus_wdata  (bus.BusWData),
    .load_data  (load_data)
  );

  // Next-state decode; a completing response wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_cap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (illegal || misalign) begin
            next_state = ST_DONE;
            fin        = 1'b1;
            fin_err    = 1'b1;
          end else begin
            next_state = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (bus.BusGnt && we_q) begin
          next_state = ST_DONE;
          fin        = 1'b1;
          fin_err    = bus.BusErr;
        end else if (bus.BusGnt && bus.BusRValid) begin
          next_state = ST_DONE;
          fin        = 1'b1;
          fin_cap    = 1'b1;
          fin_err    = bus.BusErr;
        end else if (timeout_hit) begin
          next_state = ST_DONE;
          fin        = 1'b1;
          fin_err    = 1'b1;
        end else if (bus.BusGnt) begin
          next_state = ST_RSP;
        end
      end
      ST_RSP: begin
        if (bus.BusRValid) begin
          next_state = ST_DONE;
          fin        = 1'b1;
          fin_cap    = 1'b1;
          fin_err    = bus.BusErr;
        end else if (timeout_hit) begin
          next_state = ST_DONE;
          fin        = 1'b1;
          fin_err    = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State, counter, request, request latches and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= F3_W;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      req_q <= (next_state == ST_REQ);
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (state == ST_REQ || state == ST_RSP) begin
        cnt <= cnt + CW'(1);
      end
      if (start) begin
        addr_q  <= ALUResultM;
        wdata_q <= WriteDataM;
        f3_q    <= Funct3M;
        we_q    <= MemWriteM;
      end
      if (fin) begin
        err_q   <= fin_err;
        rdata_q <= (fin_cap && !fin_err) ? load_data : 32'd0;
      end else if (state == ST_DONE) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  assign bus.BusReq  = req_q;
  assign bus.BusWe   = we_q;
  assign bus.BusAddr = {addr_q[31:2], 2'b00};

  // IDLE stalls combinationally as soon as an access shows up; DONE releases.
  always_comb begin
    StallM = 1'b0;
    case (state)
      ST_IDLE: StallM = MemReadM || MemWriteM;
      ST_REQ,
      ST_RSP:  StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  assign ReadDataM = rdata_q;
  assign ErrM      = err_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random loads/stores checked
// against an arithmetic reference model through an expected-value queue.
module tb_load_store_unit;
  import rv32i_lsu_pkg::*;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        ErrM;
  lsu_state_t  state_dbg;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .ErrM       (ErrM),
    .bus        (bus_if),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  // Observations from the last access
  bit          obs_done;
  int          obs_stall;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_done_req;
  logic        obs_after_stall, obs_after_req;
  bit          obs_bus, obs_stable;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus_if.BusGnt    = 1'b0;
    bus_if.BusRValid = 1'b0;
    bus_if.BusErr    = 1'b0;
    bus_if.BusRData  = $urandom;
  endtask

  // Reference model
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit model_misalign(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz = size_of(f3);
    return (sz == 2 && (addr % 2) != 0) || (sz == 4 && (addr % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int sz = size_of(f3);
    if (sz == 1) begin
      v = (rdata >> (8 * (addr % 4))) & 32'hFF;
      if (f3 == 3'd0 && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32768) v = v | 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    if (sz == 1) return 4'(1 << (addr % 4));
    if (sz == 2) return 4'(3 << (2 * ((addr % 4) / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wdata);
    int sz = size_of(f3);
    if (sz == 1) return (wdata & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wdata & 32'hFFFF) * 32'h0001_0001;
    return wdata;
  endfunction

  // Driver: present one access and act as the memory with given delays
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int gnt_wait,
                            input int rv_wait, input bit berr, input int limit);
    int reqc = 0;
    int since_g = -1;
    obs_done = 0; obs_bus = 0; obs_stable = 1; obs_stall = 0;
    obs_rdata = 'x; obs_err = 1'bx; obs_done_req = 1'bx;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wdata;
    for (int cyc = 0; cyc < limit && !obs_done; cyc++) begin
      idle_bus();
      if (bus_if.BusReq) begin
        if (!obs_bus) begin
          obs_bus = 1; obs_addr = bus_if.BusAddr; obs_we = bus_if.BusWe;
          obs_be = bus_if.BusBe; obs_wdata = bus_if.BusWData;
        end else if (obs_addr !== bus_if.BusAddr || obs_we !== bus_if.BusWe ||
                     obs_be !== bus_if.BusBe || obs_wdata !== bus_if.BusWData) begin
          obs_stable = 0;
        end
        if (since_g < 0 && reqc == gnt_wait) begin
          bus_if.BusGnt = 1'b1;
          since_g = 0;
          if (wr) bus_if.BusErr = berr;
        end
      end
      if (rd && since_g == rv_wait) begin
        bus_if.BusRValid = 1'b1;
        bus_if.BusRData  = rdata;
        bus_if.BusErr    = berr;
      end
      #1;
      if (!StallM) begin
        obs_done = 1; obs_rdata = ReadDataM; obs_err = ErrM; obs_done_req = bus_if.BusReq;
      end else begin
        obs_stall++;
        if (bus_if.BusReq) reqc++;
        if (since_g >= 0) since_g++;
        @(negedge clk);
      end
    end
    @(negedge clk);
    MemReadM = 0; MemWriteM = 0;
    idle_bus();
    #1;
    obs_after_stall = StallM;
    obs_after_req   = bus_if.BusReq;
  endtask

  // Scoreboard: model predicts, driver runs, results compared in order
  task automatic issue(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int g, input int rv, input bit berr);
    int nat;
    logic [31:0] e_stall, e_rdata, e_err, e_bus;
    if ((rd && wr) || model_misalign(f3, addr)) begin
      e_stall = 1; e_err = 1; e_rdata = 0; e_bus = 0;
    end else begin
      e_bus = 1;
      nat = wr ? g + 1 : g + 1 + rv;
      if (nat > TO) begin
        e_stall = 1 + TO; e_err = 1; e_rdata = 0;
      end else begin
        e_stall = 1 + nat; e_err = berr;
        e_rdata = (wr || berr) ? 32'd0 : model_load(f3, addr, rdata);
      end
    end
    exp_q.push_back(e_stall);
    exp_q.push_back(e_rdata);
    exp_q.push_back(e_err);
    exp_q.push_back(e_bus);
    exp_q.push_back({addr[31:2], 2'b00});
    exp_q.push_back(32'(wr));
    exp_q.push_back(32'(model_be(f3, addr)));
    exp_q.push_back(model_wdata(f3, wdata));

    run_access(rd, wr, f3, addr, wdata, rdata, g, rv, berr, 400);

    check({tag, ".done"}, 32'(obs_done), 32'd1);
    check({tag, ".stall"}, 32'(obs_stall), exp_q.pop_front());
    check({tag, ".rdata"}, obs_rdata, exp_q.pop_front());
    check({tag, ".err"}, 32'(obs_err), exp_q.pop_front());
    check({tag, ".bus_seen"}, 32'(obs_bus), exp_q.pop_front());
    check({tag, ".req_in_done"}, 32'(obs_done_req), 32'd0);
    check({tag, ".stall_after"}, 32'(obs_after_stall), 32'd0);
    check({tag, ".req_after"}, 32'(obs_after_req), 32'd0);
    e_bus = exp_q.pop_front();
    e_rdata = exp_q.pop_front();
    e_err = exp_q.pop_front();
    e_stall = exp_q.pop_front();
    if (obs_bus) begin
      check({tag, ".stable"}, 32'(obs_stable), 32'd1);
      check({tag, ".addr"}, obs_addr, e_bus);
      check({tag, ".we"}, 32'(obs_we), e_rdata);
      if (wr) begin
        check({tag, ".be"}, 32'(obs_be), e_err);
        check({tag, ".wdata"}, obs_wdata, e_stall);
      end
    end
  endtask

  initial begin
    int sel;
    bit rd, wr;
    logic [2:0] f3;

    // Reset
    rst = 1'b0;
    MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.stall", 32'(StallM), 32'd0);
    check("reset.busreq", 32'(bus_if.BusReq), 32'd0);
    check("reset.rdata", ReadDataM, 32'd0);
    check("reset.err", 32'(ErrM), 32'd0);
    check("reset.state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;

    // Directed cases
    issue("lb_0x103", 1, 0, F3_B, 32'h103, 32'h0, 32'h80FF_FFFF, 0, 1, 0);
    issue("sh_0x202", 0, 1, F3_H, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    issue("lw_0x101", 1, 0, F3_W, 32'h101, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    issue("lhu_0x0e", 1, 0, F3_HU, 32'h0E, 32'h0, 32'h9876_5432, 2, 3, 0);
    issue("lw_fast", 1, 0, F3_W, 32'h40, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
    issue("sb_err", 0, 1, F3_B, 32'h301, 32'h55, 32'h0, 1, 0, 1);
    issue("lh_err", 1, 0, F3_H, 32'h402, 32'h0, 32'hFFFF_FFFF, 0, 2, 1);
    issue("rd_wr_both", 1, 1, F3_W, 32'h500, 32'h1, 32'h0, 0, 0, 0);
    issue("timeout", 1, 0, F3_W, 32'h600, 32'h0, 32'h1234_5678, 300, 0, 0);

    // Stray grant/response while idle
    @(negedge clk);
    bus_if.BusGnt = 1; bus_if.BusRValid = 1; bus_if.BusErr = 1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("stray.state", 32'(state_dbg), 32'(ST_IDLE));
      check("stray.stall", 32'(StallM), 32'd0);
      check("stray.err", 32'(ErrM), 32'd0);
    end
    idle_bus();

    // Reset while waiting for a read response
    @(negedge clk);
    MemReadM = 1; Funct3M = F3_W; ALUResultM = 32'h700;
    @(negedge clk);
    bus_if.BusGnt = 1;
    @(negedge clk);
    bus_if.BusGnt = 0;
    #1;
    check("rst_rsp.in_rsp", 32'(state_dbg), 32'(ST_RSP));
    rst = 1'b0; bus_if.BusRValid = 1; bus_if.BusRData = 32'hAAAA_5555;
    @(negedge clk);
    rst = 1'b1; MemReadM = 0;
    repeat (3) begin
      #1;
      check("rst_rsp.state", 32'(state_dbg), 32'(ST_IDLE));
      check("rst_rsp.stall", 32'(StallM), 32'd0);
      check("rst_rsp.err", 32'(ErrM), 32'd0);
      check("rst_rsp.rdata", ReadDataM, 32'd0);
      @(negedge clk);
    end
    idle_bus();

    // Random accesses
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 5);
      wr  = (sel == 0) || (sel >= 6);
      f3  = rd ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      issue($sformatf("rand%0d", i), rd, wr, f3, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
